// File: rtl/vip_core_adapter_if.sv
// Signal bundle between the VIP flow-control wrapper and the core adapter.
// The master modport is the adapter's view; slave is the surrounding environment.
interface vip_core_adapter_if #(
    parameter int BITS_PER_SYMBOL = 8,
    parameter int IN_SYMBOLS      = 3,
    parameter int OUT_SYMBOLS     = 1
);
    localparam int IN_W  = BITS_PER_SYMBOL * IN_SYMBOLS;
    localparam int OUT_W = BITS_PER_SYMBOL * OUT_SYMBOLS;

    logic             stall_in;
    logic             read;
    logic [IN_W-1:0]  data_in;
    logic             end_of_video;
    logic [15:0]      width_in;
    logic [15:0]      height_in;
    logic [3:0]       interlaced_in;
    logic             vip_ctrl_valid;
    logic             stall_out;
    logic             write;
    logic [OUT_W-1:0] data_out;
    logic             end_of_video_out;
    logic [15:0]      width_out;
    logic [15:0]      height_out;
    logic [3:0]       interlaced_out;
    logic             vip_ctrl_busy;
    logic             vip_ctrl_send;
    logic             core_wr_en;
    logic [IN_W-1:0]  core_din;
    logic             core_full;
    logic             core_rd_en;
    logic [OUT_W-1:0] core_dout;
    logic             core_empty;
    logic [2:0]       status;

    modport master (
        input  stall_in, data_in, end_of_video, width_in, height_in, interlaced_in,
               vip_ctrl_valid, stall_out, vip_ctrl_busy, core_full, core_dout, core_empty,
        output read, write, data_out, end_of_video_out, width_out, height_out,
               interlaced_out, vip_ctrl_send, core_wr_en, core_din, core_rd_en, status
    );

    modport slave (
        output stall_in, data_in, end_of_video, width_in, height_in, interlaced_in,
               vip_ctrl_valid, stall_out, vip_ctrl_busy, core_full, core_dout, core_empty,
        input  read, write, data_out, end_of_video_out, width_out, height_out,
               interlaced_out, vip_ctrl_send, core_wr_en, core_din, core_rd_en, status
    );
endinterface

// File: rtl/vip_core_adapter.sv
// Bridge between VIP stall/read/write flow control and a FIFO-fronted pixel-only core.
// Optional macro FLUSH_EN: push FLUSH_PIXELS zero words per frame and drop the core's leading outputs.
module vip_core_adapter #(
    parameter int BITS_PER_SYMBOL = 8,
    parameter int IN_SYMBOLS      = 3,
    parameter int OUT_SYMBOLS     = 1,
    parameter int SKID_DEPTH      = 4,
    parameter int CNT_W           = 22,
    parameter int FLUSH_PIXELS    = 0
) (
    input  logic               clk,
    input  logic               rst,
    vip_core_adapter_if.master bus
);
    localparam int IN_W  = BITS_PER_SYMBOL * IN_SYMBOLS;
    localparam int OUT_W = BITS_PER_SYMBOL * OUT_SYMBOLS;
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam logic [PTR_W:0]   SKID_FULL = (PTR_W+1)'(SKID_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, STREAM, TRIM, DRAIN
`ifdef FLUSH_EN
        , FLUSH
`endif
    } state_t;

`ifdef FLUSH_EN
    localparam state_t END_STATE = FLUSH;
    localparam logic [CNT_W-1:0] FLUSH_N = CNT_W'(FLUSH_PIXELS);
    logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next, discard_cnt_reg;
    logic             discard;
`else
    localparam state_t END_STATE = DRAIN;
`endif

    state_t           state_reg, state_next;
    logic             run_reg;
    logic [CNT_W-1:0] in_cnt_reg, in_cnt_next, frame_pix_reg, frame_pix_next;
    logic [CNT_W-1:0] pop_cnt_reg, frame_area, frame_pix_eff;
    logic [15:0]      width_reg, height_reg;
    logic [3:0]       interlaced_reg;
    logic             send_reg, frame_done_reg, frame_done_next;
    logic             short_reg, short_set, overrun_reg, overrun_set, last_popped_reg;
    logic             read_c, accept, wr_en_c, last_in;
    logic [IN_W-1:0]  din_c;

    logic [OUT_W:0]   skid_mem [SKID_DEPTH];
    logic [OUT_W:0]   head;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             skid_valid, rd_en_c, push, pop, tag, tag_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_reg      <= 16'd640;
            height_reg     <= 16'd480;
            interlaced_reg <= 4'd0;
            send_reg       <= 1'b0;
        end else begin
            if (bus.vip_ctrl_valid) begin
                width_reg      <= bus.width_in;
                height_reg     <= bus.height_in;
                interlaced_reg <= bus.interlaced_in;
            end
            send_reg <= bus.vip_ctrl_valid & ~bus.vip_ctrl_busy;
        end
    end

    // Input gating deliberately ignores stall_out; the skid absorbs downstream back-pressure.
    always_comb begin
        read_c = 1'b0;
        case (state_reg)
            IDLE, STREAM: read_c = run_reg & ~bus.core_full;
            TRIM:         read_c = run_reg;
            default:      read_c = 1'b0;
        endcase
    end

    assign accept        = read_c & ~bus.stall_in;
    assign frame_area    = CNT_W'(width_reg) * CNT_W'(height_reg);
    assign frame_pix_eff = (state_reg == IDLE) ? frame_area : frame_pix_reg;
    assign last_in       = (in_cnt_reg == frame_pix_eff - CNT_ONE);

    always_comb begin
        state_next      = state_reg;
        in_cnt_next     = in_cnt_reg;
        frame_pix_next  = frame_pix_reg;
        wr_en_c         = 1'b0;
        din_c           = '0;
        short_set       = 1'b0;
        overrun_set     = 1'b0;
        frame_done_next = 1'b0;
`ifdef FLUSH_EN
        flush_cnt_next  = '0;
`endif
        case (state_reg)
            IDLE, STREAM: begin
                if (accept) begin
                    wr_en_c        = 1'b1;
                    din_c          = bus.data_in;
                    in_cnt_next    = in_cnt_reg + CNT_ONE;
                    frame_pix_next = frame_pix_eff;
                    state_next     = STREAM;
                    if (bus.end_of_video && !last_in) begin
                        frame_pix_next = in_cnt_reg + CNT_ONE;
                        short_set      = 1'b1;
                        state_next     = END_STATE;
                    end else if (last_in) begin
                        state_next = bus.end_of_video ? END_STATE : TRIM;
                    end
                    if (state_next != STREAM) in_cnt_next = '0;
                end
            end
            TRIM: begin
                if (accept) begin
                    overrun_set = 1'b1;
                    if (bus.end_of_video) state_next = END_STATE;
                end
            end
`ifdef FLUSH_EN
            FLUSH: begin
                flush_cnt_next = flush_cnt_reg;
                if (flush_cnt_reg == FLUSH_N) begin
                    state_next = DRAIN;
                end else if (!bus.core_full) begin
                    wr_en_c        = 1'b1;
                    flush_cnt_next = flush_cnt_reg + CNT_ONE;
                end
            end
`endif
            DRAIN: begin
                if (last_popped_reg || tag_pop) begin
                    frame_done_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            run_reg         <= 1'b0;
            in_cnt_reg      <= '0;
            frame_pix_reg   <= '0;
            frame_done_reg  <= 1'b0;
            short_reg       <= 1'b0;
            overrun_reg     <= 1'b0;
            last_popped_reg <= 1'b0;
`ifdef FLUSH_EN
            flush_cnt_reg   <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            run_reg         <= 1'b1;
            in_cnt_reg      <= in_cnt_next;
            frame_pix_reg   <= frame_pix_next;
            frame_done_reg  <= frame_done_next;
            short_reg       <= short_reg | short_set;
            overrun_reg     <= overrun_reg | overrun_set;
            last_popped_reg <= (state_reg == DRAIN) ? 1'b0 : (last_popped_reg | tag_pop);
`ifdef FLUSH_EN
            flush_cnt_reg   <= flush_cnt_next;
`endif
        end
    end

    // Output skid: core words carry their end-of-frame tag alongside the pixel.
    assign skid_valid = (count_reg != '0);
    assign head       = skid_mem[rd_ptr_reg];
    assign rd_en_c    = ~bus.core_empty & (count_reg != SKID_FULL);
    assign pop        = skid_valid & ~bus.stall_out;
    assign tag_pop    = pop & head[OUT_W];
    assign tag        = (pop_cnt_reg == frame_pix_reg - CNT_ONE);

`ifdef FLUSH_EN
    assign discard = (discard_cnt_reg != FLUSH_N);
    assign push    = rd_en_c & ~discard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    discard_cnt_reg <= '0;
        else if (push && tag)       discard_cnt_reg <= '0;
        else if (rd_en_c && discard) discard_cnt_reg <= discard_cnt_reg + CNT_ONE;
    end
`else
    assign push = rd_en_c;
`endif

    always_ff @(posedge clk) begin
        if (push) skid_mem[wr_ptr_reg] <= {tag, bus.core_dout};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            pop_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg  <= wr_ptr_reg + PTR_W'(1);
                pop_cnt_reg <= tag ? '0 : pop_cnt_reg + CNT_ONE;
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign bus.read             = read_c;
    assign bus.core_wr_en       = wr_en_c;
    assign bus.core_din         = din_c;
    assign bus.core_rd_en       = rd_en_c;
    assign bus.write            = skid_valid;
    assign bus.data_out         = skid_valid ? head[OUT_W-1:0] : '0;
    assign bus.end_of_video_out = skid_valid & head[OUT_W];
    assign bus.width_out        = width_reg;
    assign bus.height_out       = height_reg;
    assign bus.interlaced_out   = interlaced_reg;
    assign bus.vip_ctrl_send    = send_reg;
    assign bus.status           = {overrun_reg, short_reg, frame_done_reg};
endmodule

// File: tb/tb_vip_core_adapter.sv
// Directed bench for vip_core_adapter with a FIFO core model (pass-through, or 3-word delay under FLUSH_EN).
module tb_vip_core_adapter;
    localparam int CORE_DEPTH = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vip_core_adapter_if #(.BITS_PER_SYMBOL(8), .IN_SYMBOLS(3), .OUT_SYMBOLS(1)) bus ();

    vip_core_adapter #(
        .BITS_PER_SYMBOL(8), .IN_SYMBOLS(3), .OUT_SYMBOLS(1),
        .SKID_DEPTH(4), .CNT_W(22), .FLUSH_PIXELS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Core model: first-word-fall-through FIFO behind an optional 3-word delay line.
    logic [7:0] core_mem [16];
    logic [3:0] core_wp, core_rp;
    logic [7:0] dly0, dly1, dly2, core_word;
`ifdef FLUSH_EN
    assign core_word = dly2;
    localparam int EXP_ZERO = 3;
`else
    assign core_word = bus.core_din[7:0];
    localparam int EXP_ZERO = 0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_wp <= '0; core_rp <= '0;
            dly0 <= '0; dly1 <= '0; dly2 <= '0;
        end else begin
            if (bus.core_wr_en) begin
                core_mem[core_wp] <= core_word;
                core_wp <= core_wp + 4'd1;
                dly0 <= bus.core_din[7:0];
                dly1 <= dly0;
                dly2 <= dly1;
            end
            if (bus.core_rd_en) core_rp <= core_rp + 4'd1;
        end
    end
    assign bus.core_empty = (core_wp == core_rp);
    assign bus.core_full  = ((core_wp - core_rp) >= 4'(CORE_DEPTH));
    assign bus.core_dout  = core_mem[core_rp];

    int n_checks = 0;
    int n_pass   = 0;
    int done_n, wr_n, zero_n, gate_err, full_n;
    logic in_phase = 1'b0;
    logic [7:0] out_data [$];
    logic       out_eov  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.write && !bus.stall_out) begin
                out_data.push_back(bus.data_out);
                out_eov.push_back(bus.end_of_video_out);
            end
            if (bus.status[0]) done_n++;
            if (bus.core_wr_en) begin
                if (bus.core_din == '0) zero_n++;
                else wr_n++;
            end
            if (in_phase && !bus.read && !bus.core_full) gate_err++;
            if (in_phase && !bus.read && bus.core_full) full_n++;
        end
    end

    task automatic clear_mon();
        out_data.delete();
        out_eov.delete();
        done_n = 0; wr_n = 0; zero_n = 0; gate_err = 0; full_n = 0;
    endtask

    task automatic send_frame(input int n, input int eov_at, input logic [7:0] base);
        in_phase = 1'b1;
        for (int i = 1; i <= n; i++) begin
            automatic logic took = 1'b0;
            automatic int guard = 0;
            bus.data_in      = {8'hC3, 8'h3C, 8'(base + 8'(i))};
            bus.end_of_video = (i == eov_at);
            bus.stall_in     = 1'b0;
            while (!took) begin
                @(negedge clk);
                took = bus.read;
                @(posedge clk);
                #1;
                guard++;
                if (!took && guard > 200) begin
                    chk("accept_timeout", 32'(guard), 32'd0);
                    took = 1'b1;
                end
            end
        end
        bus.stall_in     = 1'b1;
        bus.end_of_video = 1'b0;
        in_phase         = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_n == 0 && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (done_n == 0) chk("frame_done_timeout", 32'(guard), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic verify_frame(input string tag, input int n, input logic [7:0] base, input int writes);
        chk({tag, "_out_count"}, 32'(out_data.size()), 32'(n));
        for (int i = 0; i < n && i < out_data.size(); i++) begin
            automatic logic [7:0] e = 8'(base + 8'(i + 1));
            chk({tag, "_data"}, {24'd0, out_data[i]}, {24'd0, e});
            chk({tag, "_eov"}, {31'd0, out_eov[i]}, {31'd0, (i == n - 1)});
        end
        chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
        chk({tag, "_core_writes"}, 32'(wr_n), 32'(writes));
        chk({tag, "_flush_writes"}, 32'(zero_n), 32'(EXP_ZERO));
    endtask

    task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                             input logic busy);
        bus.width_in       = w;
        bus.height_in      = h;
        bus.interlaced_in  = il;
        bus.vip_ctrl_busy  = busy;
        bus.vip_ctrl_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.vip_ctrl_valid = 1'b0;
        chk("ctrl_width", {16'd0, bus.width_out}, {16'd0, w});
        chk("ctrl_height", {16'd0, bus.height_out}, {16'd0, h});
        chk("ctrl_interlaced", {28'd0, bus.interlaced_out}, {28'd0, il});
        chk("ctrl_send", {31'd0, bus.vip_ctrl_send}, busy ? 32'd0 : 32'd1);
        @(posedge clk);
        #1;
        chk("ctrl_send_clear", {31'd0, bus.vip_ctrl_send}, 32'd0);
    endtask

    task automatic stall_after_three(output int hold);
        int guard = 0;
        hold = 0;
        while (!(bus.write && bus.data_out == 8'h23) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 300) begin
            chk("stall_wait_timeout", 32'(guard), 32'd0);
        end else begin
            bus.stall_out = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (bus.write && bus.data_out == 8'h23) hold++;
            end
            @(posedge clk);
            #1;
            bus.stall_out = 1'b0;
        end
    endtask

    initial begin
        int hold;
        bus.stall_in = 1'b1; bus.data_in = '0; bus.end_of_video = 1'b0;
        bus.width_in = '0; bus.height_in = '0; bus.interlaced_in = '0;
        bus.vip_ctrl_valid = 1'b0; bus.vip_ctrl_busy = 1'b0; bus.stall_out = 1'b0;
        clear_mon();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_width", {16'd0, bus.width_out}, 32'd640);
        chk("rst_height", {16'd0, bus.height_out}, 32'd480);
        chk("rst_interlaced", {28'd0, bus.interlaced_out}, 32'd0);
        chk("rst_send", {31'd0, bus.vip_ctrl_send}, 32'd0);
        chk("rst_read", {31'd0, bus.read}, 32'd0);
        chk("rst_write", {31'd0, bus.write}, 32'd0);
        chk("rst_core_wr_en", {31'd0, bus.core_wr_en}, 32'd0);
        chk("rst_core_rd_en", {31'd0, bus.core_rd_en}, 32'd0);
        chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);
        chk("rst_eov_out", {31'd0, bus.end_of_video_out}, 32'd0);
        chk("rst_status", {29'd0, bus.status}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 4x2 frame, no stalls
        send_ctrl(16'd4, 16'd2, 4'd5, 1'b0);
        clear_mon();
        send_frame(8, 8, 8'h10);
        wait_done();
        verify_frame("basic", 8, 8'h10, 8);

        // downstream stall while pixel 3 is presented
        clear_mon();
        fork
            send_frame(8, 8, 8'h20);
            stall_after_three(hold);
        join
        wait_done();
        verify_frame("stall", 8, 8'h20, 8);
        chk("stall_hold_cycles", 32'(hold), 32'd10);
        chk("stall_read_gating", 32'(gate_err), 32'd0);
        chk("stall_core_full_seen", {31'd0, (full_n > 0)}, 32'd1);

        // short frame: end_of_video on pixel 5
        clear_mon();
        send_frame(5, 5, 8'h30);
        wait_done();
        verify_frame("short", 5, 8'h30, 5);
        chk("short_status1", {31'd0, bus.status[1]}, 32'd1);
        chk("short_status2", {31'd0, bus.status[2]}, 32'd0);

        // long frame: 10 inputs, only 8 reach the core
        clear_mon();
        send_frame(10, 10, 8'h40);
        wait_done();
        verify_frame("long", 8, 8'h40, 8);
        chk("long_status2", {31'd0, bus.status[2]}, 32'd1);

        // mid-frame control packets: busy suppresses send, frame size unchanged
        clear_mon();
        fork
            send_frame(8, 8, 8'h50);
            begin
                repeat (3) @(posedge clk);
                #1;
                send_ctrl(16'd2, 16'd2, 4'd0, 1'b1);
                send_ctrl(16'd2, 16'd2, 4'd0, 1'b0);
            end
        join
        wait_done();
        verify_frame("midctrl", 8, 8'h50, 8);

        // next frame picks up the 2x2 size
        clear_mon();
        send_frame(4, 4, 8'h60);
        wait_done();
        verify_frame("small", 4, 8'h60, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
